// File: rtl/rv_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile_pkg
// Description : Shared index type and legality helper for the RV32 register
//               file and its read channels.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_regfile_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // An index is legal when it addresses an implemented register; upper
  // address bits are deliberately not masked so RV32E sees x16..x31 as illegal.
  function automatic logic is_legal_idx(input reg_idx_t idx, input int unsigned num_regs);
    return ({27'd0, idx} < num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile_rdport
// Description : One read channel of the register file: request handshake,
//               write-bypass mux, illegal-address flag and a one-entry held
//               output stage with snapshot semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_regfile_rdport
  import rv_regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arvalid,
  output logic            arready,
  input  reg_idx_t        araddr,
  output logic            rvalid,
  input  logic            rready,
  output logic [XLEN-1:0] rdata,
  output logic            rerr,
  input  logic [XLEN-1:0] store_data,  // storage word at araddr (don't-care when illegal)
  input  logic            wr_commit,   // a legal nonzero write is being accepted this cycle
  input  reg_idx_t        wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic            accept;
  logic            legal;
  logic            hit;
  logic [XLEN-1:0] load_data;

  // The stage can take a new request when empty or being drained this cycle;
  // nothing is accepted while reset is asserted.
  assign arready = !rst && (!rvalid || rready);
  assign accept  = arvalid && arready;
  assign legal   = is_legal_idx(araddr, NUM_REGS);
  assign hit     = (BYPASS != 0) && wr_commit && (wr_addr == araddr);

  // Select the value captured on accept: x0 and illegal indices read zero,
  // a colliding write wins over storage when bypass is enabled.
  always_comb begin
    load_data = store_data;
    if (!legal || (araddr == '0)) begin
      load_data = '0;
    end else if (hit) begin
      load_data = wr_data;
    end
  end

  // Output stage: load on accept, drop valid on consume, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rerr   <= 1'b0;
    end else if (accept) begin
      rvalid <= 1'b1;
      rdata  <= load_data;
      rerr   <= !legal;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile
// Description : Parametrised RV32/RV32E integer register file with one write
//               port and NUM_RD independent registered read channels.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_regfile
  import rv_regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           i_rd_arvalid,
  output logic [NUM_RD-1:0]           o_rd_arready,
  input  logic [NUM_RD*REG_IDX_W-1:0] i_rd_araddr,
  output logic [NUM_RD-1:0]           o_rd_rvalid,
  input  logic [NUM_RD-1:0]           i_rd_rready,
  output logic [NUM_RD*XLEN-1:0]      o_rd_rdata,
  output logic [NUM_RD-1:0]           o_rd_rerr,
  input  logic                        i_wr_wvalid,
  output logic                        o_wr_wready,
  input  reg_idx_t                    i_wr_waddr,
  input  logic [XLEN-1:0]             i_wr_wdata,
  output logic                        o_wr_werr
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_accept;
  logic            wr_legal;
  logic            wr_commit;

  assign o_wr_wready = !rst;
  assign wr_accept   = i_wr_wvalid && o_wr_wready;
  assign wr_legal    = is_legal_idx(i_wr_waddr, NUM_REGS);
  assign wr_commit   = wr_accept && wr_legal && (i_wr_waddr != '0);

  // Architectural storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[i_wr_waddr[IDX_W-1:0]] <= i_wr_wdata;
    end
  end

  // One-cycle error pulse for an accepted write to an unimplemented register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr_werr <= 1'b0;
    end else begin
      o_wr_werr <= wr_accept && !wr_legal;
    end
  end

  generate
    for (genvar c = 0; c < NUM_RD; c++) begin : g_rd
      reg_idx_t        addr;
      logic [XLEN-1:0] store;

      assign addr = i_rd_araddr[c*REG_IDX_W +: REG_IDX_W];
      // Truncated index only selects a word; the channel zeroes illegal reads.
      assign store = regs[addr[IDX_W-1:0]];

      rv_regfile_rdport #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
      ) u_rdport (
        .clk        (clk),
        .rst        (rst),
        .arvalid    (i_rd_arvalid[c]),
        .arready    (o_rd_arready[c]),
        .araddr     (addr),
        .rvalid     (o_rd_rvalid[c]),
        .rready     (i_rd_rready[c]),
        .rdata      (o_rd_rdata[c*XLEN +: XLEN]),
        .rerr       (o_rd_rerr[c]),
        .store_data (store),
        .wr_commit  (wr_commit),
        .wr_addr    (i_wr_waddr),
        .wr_data    (i_wr_wdata)
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_regfile
// Description : Self-checking bench for rv_regfile. Three instances (RV32 with
//               bypass, RV32 without bypass, RV32E with bypass) share one
//               stimulus stream and are compared every cycle against an
//               array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_regfile;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NRD-1:0]      arvalid = '0;
  logic [NRD*5-1:0]    araddr  = '0;
  logic [NRD-1:0]      rready  = '0;
  logic                wvalid  = 1'b0;
  logic [4:0]          waddr   = '0;
  logic [XLEN-1:0]     wdata   = '0;

  logic [NRD-1:0]      arready [NDUT];
  logic [NRD-1:0]      rvalid  [NDUT];
  logic [NRD*XLEN-1:0] rdata   [NDUT];
  logic [NRD-1:0]      rerr    [NDUT];
  logic                wready  [NDUT];
  logic                werr    [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [XLEN-1:0] mem [NDUT][32];
  bit              ev  [NDUT][NRD];
  logic [XLEN-1:0] ed  [NDUT][NRD];
  bit              ee  [NDUT][NRD];
  bit              ewerr [NDUT];

  always #5 clk = ~clk;

  rv_regfile #(.XLEN(XLEN), .NUM_REGS(32), .NUM_RD(NRD), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst),
    .i_rd_arvalid(arvalid), .o_rd_arready(arready[0]), .i_rd_araddr(araddr),
    .o_rd_rvalid(rvalid[0]), .i_rd_rready(rready), .o_rd_rdata(rdata[0]), .o_rd_rerr(rerr[0]),
    .i_wr_wvalid(wvalid), .o_wr_wready(wready[0]), .i_wr_waddr(waddr), .i_wr_wdata(wdata),
    .o_wr_werr(werr[0])
  );

  rv_regfile #(.XLEN(XLEN), .NUM_REGS(32), .NUM_RD(NRD), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst(rst),
    .i_rd_arvalid(arvalid), .o_rd_arready(arready[1]), .i_rd_araddr(araddr),
    .o_rd_rvalid(rvalid[1]), .i_rd_rready(rready), .o_rd_rdata(rdata[1]), .o_rd_rerr(rerr[1]),
    .i_wr_wvalid(wvalid), .o_wr_wready(wready[1]), .i_wr_waddr(waddr), .i_wr_wdata(wdata),
    .o_wr_werr(werr[1])
  );

  rv_regfile #(.XLEN(XLEN), .NUM_REGS(16), .NUM_RD(NRD), .BYPASS(1)) u_dut_rv32e (
    .clk(clk), .rst(rst),
    .i_rd_arvalid(arvalid), .o_rd_arready(arready[2]), .i_rd_araddr(araddr),
    .o_rd_rvalid(rvalid[2]), .i_rd_rready(rready), .o_rd_rdata(rdata[2]), .o_rd_rerr(rerr[2]),
    .i_wr_wvalid(wvalid), .o_wr_wready(wready[2]), .i_wr_waddr(waddr), .i_wr_wdata(wdata),
    .o_wr_werr(werr[2])
  );

  function automatic int nregs_of(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic bit byp_of(input int k);
    return (k != 1);
  endfunction

  function automatic logic [XLEN-1:0] rd(input int k, input int c);
    return rdata[k][c*XLEN +: XLEN];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      for (int r = 0; r < 32; r++) mem[k][r] = '0;
      for (int c = 0; c < NRD; c++) begin
        ev[k][c] = 1'b0;
        ed[k][c] = '0;
        ee[k][c] = 1'b0;
      end
      ewerr[k] = 1'b0;
    end
  endtask

  // Apply the architectural rules for one rising edge with the current inputs.
  task automatic model_edge();
    int  n;
    int  a;
    bit  wlegal;
    bit  rdy;
    for (int k = 0; k < NDUT; k++) begin
      n      = nregs_of(k);
      wlegal = (int'(waddr) < n);
      for (int c = 0; c < NRD; c++) begin
        rdy = !ev[k][c] || rready[c];
        if (arvalid[c] && rdy) begin
          a        = int'(araddr[c*5 +: 5]);
          ev[k][c] = 1'b1;
          ee[k][c] = (a >= n);
          if (a == 0 || a >= n)                                       ed[k][c] = '0;
          else if (byp_of(k) && wvalid && wlegal && int'(waddr) == a) ed[k][c] = wdata;
          else                                                        ed[k][c] = mem[k][a];
        end else if (rready[c]) begin
          ev[k][c] = 1'b0;
        end
      end
      ewerr[k] = wvalid && !wlegal;
      if (wvalid && wlegal && waddr != 0) mem[k][waddr] = wdata;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      for (int c = 0; c < NRD; c++) begin
        check($sformatf("rvalid d%0d c%0d", k, c), 32'(rvalid[k][c]), 32'(ev[k][c]));
        check($sformatf("arready d%0d c%0d", k, c), 32'(arready[k][c]), 32'(!ev[k][c] || rready[c]));
        if (ev[k][c]) begin
          check($sformatf("rdata d%0d c%0d", k, c), rd(k, c), ed[k][c]);
          check($sformatf("rerr d%0d c%0d", k, c), 32'(rerr[k][c]), 32'(ee[k][c]));
        end
      end
      check($sformatf("wready d%0d", k), 32'(wready[k]), 32'd1);
      check($sformatf("werr d%0d", k), 32'(werr[k]), 32'(ewerr[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset between edges, check immediate effect, release a cycle later.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      for (int c = 0; c < NRD; c++) begin
        check($sformatf("rst rvalid d%0d c%0d", k, c), 32'(rvalid[k][c]), 32'd0);
        check($sformatf("rst arready d%0d c%0d", k, c), 32'(arready[k][c]), 32'd0);
      end
      check($sformatf("rst wready d%0d", k), 32'(wready[k]), 32'd0);
      check($sformatf("rst werr d%0d", k), 32'(werr[k]), 32'd0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 compare_all();
  endtask

  task automatic set_read(input int c, input int a);
    araddr[c*5 +: 5] = 5'(a);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 compare_all();

    // Sweep all indices on both channels straight out of reset.
    rready = 2'b11;
    for (int i = 0; i < 32; i++) begin
      arvalid = 2'b11;
      set_read(0, i);
      set_read(1, 31 - i);
      step();
      check("sweep rdata", rd(0, 0), 32'd0);
      check("sweep rerr", 32'(rerr[0][0]), 32'd0);
    end

    // Write then read back; x0 discards writes.
    arvalid = 2'b00;
    wvalid = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    wvalid = 1'b0; arvalid = 2'b01; set_read(0, 5);
    step();
    check("x5 readback", rd(0, 0), 32'hDEADBEEF);
    arvalid = 2'b00; wvalid = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    step();
    wvalid = 1'b0; arvalid = 2'b01; set_read(0, 0);
    step();
    check("x0 reads zero", rd(0, 0), 32'd0);

    // Same-cycle write and read of x7.
    wvalid = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    arvalid = 2'b01; set_read(0, 7);
    step();
    check("bypass on", rd(0, 0), 32'hA5A5A5A5);
    check("bypass off", rd(1, 0), 32'd0);

    // Backpressure with snapshot semantics.
    arvalid = 2'b00; wvalid = 1'b1; waddr = 5'd3; wdata = 32'h11;
    step();
    wvalid = 1'b0; arvalid = 2'b01; set_read(0, 3); rready = 2'b00;
    step();
    arvalid = 2'b00; wvalid = 1'b1; waddr = 5'd3; wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check("held rdata", rd(0, 0), 32'h11);
      check("held arready", 32'(arready[0][0]), 32'd0);
    end
    wvalid = 1'b0; rready = 2'b11;
    step();
    arvalid = 2'b01; set_read(0, 3);
    step();
    check("reread x3", rd(0, 0), 32'h22);

    // RV32E illegal indices.
    arvalid = 2'b01; set_read(0, 20);
    step();
    check("rv32e rerr", 32'(rerr[2][0]), 32'd1);
    check("rv32e rdata", rd(2, 0), 32'd0);
    arvalid = 2'b00; wvalid = 1'b1; waddr = 5'd20; wdata = 32'hFFFF_FFFF;
    step();
    check("rv32e werr", 32'(werr[2]), 32'd1);
    wvalid = 1'b0; arvalid = 2'b01; set_read(0, 4);
    step();
    check("rv32e werr pulse", 32'(werr[2]), 32'd0);
    check("rv32e no alias", rd(2, 0), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < NRD; c++) begin
        arvalid[c] = ($urandom_range(0, 3) != 0);
        set_read(c, int'($urandom_range(0, 31)));
        rready[c]  = ($urandom_range(0, 3) != 0);
      end
      wvalid = 1'($urandom_range(0, 1));
      waddr  = ($urandom_range(0, 3) == 0) ? araddr[4:0] : 5'($urandom_range(0, 31));
      wdata  = $urandom;
      step();
    end

    // Reset while data is held and a write is in flight.
    arvalid = 2'b11; set_read(0, 9); set_read(1, 12); rready = 2'b00;
    wvalid = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D;
    step();
    do_reset();
    wvalid = 1'b0; rready = 2'b11;
    for (int i = 0; i < 32; i++) begin
      arvalid = 2'b11;
      set_read(0, i);
      set_read(1, i);
      step();
      check("post-reset zero", rd(0, 0), 32'd0);
    end

    arvalid = 2'b00;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
